// File: rtl/bomb_module_if.sv
// Signal bundle between the bomberman sprite/VGA side and the bomb block.
//   x, y          : current VGA pixel location
//   x_b, y_b      : bomberman sprite top-left (hitbox top is y_b+8)
//   A             : bomb button, level, already debounced
//   gameover      : lives have reached zero
//   bomb_on       : pixel lies inside the armed bomb tile
//   exp_on        : pixel lies inside the explosion cross
//   bomb_active   : bomb is armed (fuse running)
//   exp_active    : explosion is being displayed
//   bomb_col/row  : latched tile coordinates of the bomb
//   fuse_frame    : bomb animation frame
//   state_dbg     : raw FSM state (0 idle, 1 armed, 2 explode, 3 cool)
// There is no handshake here: all inputs are levels sampled every clock, and
// all outputs are continuously valid.
interface bomb_module_if;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] x_b;
    logic [9:0] y_b;
    logic       A;
    logic       gameover;
    logic       bomb_on;
    logic       exp_on;
    logic       bomb_active;
    logic       exp_active;
    logic [5:0] bomb_col;
    logic [4:0] bomb_row;
    logic [1:0] fuse_frame;
    logic [1:0] state_dbg;

    modport master (
        output x, y, x_b, y_b, A, gameover,
        input  bomb_on, exp_on, bomb_active, exp_active,
        input  bomb_col, bomb_row, fuse_frame, state_dbg
    );

    modport slave (
        input  x, y, x_b, y_b, A, gameover,
        output bomb_on, exp_on, bomb_active, exp_active,
        output bomb_col, bomb_row, fuse_frame, state_dbg
    );
endinterface

// File: rtl/bomb_module.sv
// Bomb placement and timing for the bomberman arena.
// A rising edge on the bomb button in IDLE snaps a bomb to the 16x16 tile
// under the sprite hitbox centre, then the FSM runs fuse -> explosion ->
// cooldown. Per-pixel bomb_on / exp_on feed the display mux; tile position
// and status feed the collision and lives logic.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : bomb_module_if slave modport (see interface file)
module bomb_module #(
    parameter int unsigned FUSE_CYCLES = 150000000,
    parameter int unsigned EXP_CYCLES  = 25000000,
    parameter int unsigned COOL_CYCLES = 5000000,
    parameter int unsigned RANGE       = 2,
    parameter int unsigned UP_LEFT_X   = 48,
    parameter int unsigned UP_LEFT_Y   = 32
) (
    input  logic          clk,
    input  logic          reset,
    bomb_module_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPLODE = 2'd2,
        COOL    = 2'd3
    } state_t;

    // Arena is 33 columns (0..32) by 26 rows (0..25).
    localparam int unsigned LAST_COL = 32;
    localparam int unsigned LAST_ROW = 25;

    localparam int unsigned MAX_FE  = (FUSE_CYCLES > EXP_CYCLES) ? FUSE_CYCLES : EXP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_FE > COOL_CYCLES) ? MAX_FE : COOL_CYCLES;
    localparam int          TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] FUSE_LAST = TW'(FUSE_CYCLES - 1);
    localparam logic [TW-1:0] EXP_LAST  = TW'(EXP_CYCLES - 1);
    localparam logic [TW-1:0] COOL_LAST = TW'(COOL_CYCLES - 1);

    // The animation frame is tracked with its own divider instead of dividing
    // the timer, so no constant divider is needed on the 28-bit timer.
    localparam int unsigned     FRAME_DIV  = (FUSE_CYCLES / 8 > 0) ? FUSE_CYCLES / 8 : 1;
    localparam int              FW         = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FW-1:0]   FRAME_LAST = FW'(FRAME_DIV - 1);

    state_t          state;
    logic [TW-1:0]   timer;
    logic [FW-1:0]   frame_cnt;
    logic [1:0]      fuse_frame_q;
    logic            a_d;
    logic            bomb_active_q;
    logic            exp_active_q;
    logic [5:0]      col_q;
    logic [4:0]      row_q;

    logic            a_rise;
    logic [9:0]      snap_x;
    logic [9:0]      snap_y;

    assign a_rise = bus.A & ~a_d;
    // Hitbox centre: +8 in x, hitbox top (y_b+8) plus half a tile in y.
    assign snap_x = bus.x_b + 10'd8  - 10'(UP_LEFT_X);
    assign snap_y = bus.y_b + 10'd16 - 10'(UP_LEFT_Y);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            frame_cnt     <= '0;
            fuse_frame_q  <= 2'd0;
            a_d           <= 1'b0;
            bomb_active_q <= 1'b0;
            exp_active_q  <= 1'b0;
            col_q         <= 6'd0;
            row_q         <= 5'd0;
        end else begin
            a_d <= bus.A;
            if (bus.gameover) begin
                // Game over wins over any expiry in the same cycle.
                state         <= IDLE;
                timer         <= '0;
                frame_cnt     <= '0;
                fuse_frame_q  <= 2'd0;
                bomb_active_q <= 1'b0;
                exp_active_q  <= 1'b0;
                col_q         <= 6'd0;
                row_q         <= 5'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (a_rise) begin
                            state         <= ARMED;
                            timer         <= '0;
                            frame_cnt     <= '0;
                            fuse_frame_q  <= 2'd0;
                            bomb_active_q <= 1'b1;
                            col_q         <= snap_x[9:4];
                            row_q         <= snap_y[8:4];
                        end
                    end
                    ARMED: begin
                        if (timer == FUSE_LAST) begin
                            state         <= EXPLODE;
                            timer         <= '0;
                            frame_cnt     <= '0;
                            fuse_frame_q  <= 2'd0;
                            bomb_active_q <= 1'b0;
                            exp_active_q  <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                            if (frame_cnt == FRAME_LAST) begin
                                frame_cnt    <= '0;
                                fuse_frame_q <= fuse_frame_q + 2'd1;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                    EXPLODE: begin
                        if (timer == EXP_LAST) begin
                            state        <= COOL;
                            timer        <= '0;
                            exp_active_q <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    COOL: begin
                        // Button edges here are dropped, even on the last cycle.
                        if (timer == COOL_LAST) begin
                            state <= IDLE;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

    // Pixel-level bomb tile test (11-bit so the +16 edge cannot wrap).
    logic [10:0] tile_x0;
    logic [10:0] tile_y0;
    logic [10:0] px;
    logic [10:0] py;

    assign tile_x0 = 11'(UP_LEFT_X) + {1'b0, col_q, 4'b0000};
    assign tile_y0 = 11'(UP_LEFT_Y) + {2'b00, row_q, 4'b0000};
    assign px      = {1'b0, bus.x};
    assign py      = {1'b0, bus.y};

    assign bus.bomb_on = bomb_active_q
                       && (px >= tile_x0) && (px < tile_x0 + 11'd16)
                       && (py >= tile_y0) && (py < tile_y0 + 11'd16);

    // Explosion cross in tile space. Distances are taken as magnitudes so
    // nothing below tile 0 can wrap into range.
    logic [9:0] dx;
    logic [9:0] dy;
    logic [5:0] pc;
    logic [5:0] pr;
    logic [5:0] row6;
    logic [5:0] dc;
    logic [5:0] dr;
    logic       in_arena;
    logic       centre;
    logic       h_arm;
    logic       v_arm;

    always_comb begin
        dx       = bus.x - 10'(UP_LEFT_X);
        dy       = bus.y - 10'(UP_LEFT_Y);
        pc       = dx[9:4];
        pr       = dy[9:4];
        row6     = {1'b0, row_q};
        dc       = (pc >= col_q) ? (pc - col_q) : (col_q - pc);
        dr       = (pr >= row6)  ? (pr - row6)  : (row6 - pr);
        in_arena = (bus.x >= 10'(UP_LEFT_X)) && (bus.y >= 10'(UP_LEFT_Y))
                && (pc <= 6'(LAST_COL)) && (pr <= 6'(LAST_ROW));
        centre   = (pc == col_q) && (pr == row6);
        // Odd rows/columns have pillars next to the bomb, blocking that arm.
        h_arm    = (pr == row6)  && (dc <= 6'(RANGE)) && !row_q[0];
        v_arm    = (pc == col_q) && (dr <= 6'(RANGE)) && !col_q[0];
    end

    assign bus.exp_on      = exp_active_q && in_arena && (centre || h_arm || v_arm);
    assign bus.bomb_active = bomb_active_q;
    assign bus.exp_active  = exp_active_q;
    assign bus.bomb_col    = col_q;
    assign bus.bomb_row    = row_q;
    assign bus.fuse_frame  = fuse_frame_q;
    assign bus.state_dbg   = state;

endmodule

// File: doc/bomb_module.md
Name: bomb_module

Overview:
- Consumes the bomberman sprite location (x_b, y_b) and the bomb button.
- Snaps a placed bomb to the 16x16 arena tile under the sprite hitbox centre, then runs fuse, explosion and cooldown timing.
- Produces per-pixel bomb_on / exp_on flags for the display mux, plus tile coordinates and status for the collision and lives logic.
- Sits directly downstream of the bomberman motion/sprite block, alongside game_lives.

Parameters:
FUSE_CYCLES, 150000000, cycles from placement to detonation (3 s at 50 MHz)
EXP_CYCLES, 25000000, cycles the explosion is displayed (0.5 s)
COOL_CYCLES, 5000000, dead time after explosion before a new bomb is accepted
RANGE, 2, explosion arm length in tiles in each direction
UP_LEFT_X, 48, arena left edge in pixels
UP_LEFT_Y, 32, arena top edge in pixels

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
x, y  in  10 each  current VGA pixel location
x_b, y_b  in  10 each  bomberman sprite top-left (hitbox top is y_b+8)
A  in  1  bomb button, level, already debounced
gameover  in  1  lives == 0
bomb_on  out  1  pixel lies inside the armed bomb tile
exp_on  out  1  pixel lies inside the explosion cross
bomb_active  out  1  FSM in ARMED
exp_active  out  1  FSM in EXPLODE
bomb_col  out  6  latched tile column, 0..32
bomb_row  out  5  latched tile row, 0..25
fuse_frame  out  2  bomb animation frame, advances every FUSE_CYCLES/8 and wraps 3->0

Behaviour:
- Single clock. All registers use synchronous, active-high reset.
- Reset values: state IDLE, all outputs 0, timers 0, A_d 0.
- Placement request: rising edge of A (A & ~A_d), with A_d registered every cycle.
- Tile snapping: col = (x_b + 8 - UP_LEFT_X) >> 4; row = (y_b + 16 - UP_LEFT_Y) >> 4. Use 10-bit arithmetic and truncate to port widths.
- FSM states: IDLE, ARMED, EXPLODE, COOL.
  - IDLE: on a request with gameover=0, latch col/row, clear the timer, go to ARMED next cycle. bomb_active rises 1 cycle after the edge.
  - ARMED: timer counts up. At timer == FUSE_CYCLES-1, clear the timer and go to EXPLODE. Requests are ignored.
  - EXPLODE: at timer == EXP_CYCLES-1, go to COOL. Requests are ignored.
  - COOL: at timer == COOL_CYCLES-1, go to IDLE. A request in the last COOL cycle is ignored; only edges seen in IDLE count.
- fuse_frame = timer / (FUSE_CYCLES/8), modulo 4. It is valid only in ARMED and reads 0 elsewhere.
- gameover=1 in any state forces IDLE next cycle, clears col/row, and drops all outputs. The clear takes priority over timer expiry in the same cycle.
- A simultaneous request edge and expiry is resolved by the expiry transition only.
- bomb_on is combinational: ARMED & x in [UP_LEFT_X+16*col, +15] & y in [UP_LEFT_Y+16*row, +15].
- exp_on is combinational, EXPLODE only. The pixel tile is pc = (x-UP_LEFT_X)>>4 and pr = (y-UP_LEFT_Y)>>4, and the pixel must be inside the arena. exp_on is set if any of these hold:
  - centre: pc==col & pr==row.
  - horizontal arm: pr==row & |pc-col| <= RANGE & row[0]==0. On odd rows the neighbours are pillars, so the arm is suppressed.
  - vertical arm: pc==col & |pr-row| <= RANGE & col[0]==0.
  - Arms clip at column 0/32 and row 0/25. Signed compare must not wrap below 0.
- exp_on is asserted for the whole EXPLODE state regardless of the bomberman position. The lives block does the hit test using bm_hb_on & exp_on.
- Mid-ARMED reset: IDLE next edge, bomb_on low, and no explosion ever occurs.

Test Plan:
- FUSE=16, EXP=8, COOL=4. Reset, x_b=64, y_b=24, pulse A 1 cycle -> col=1, row=0; bomb_active high cycles 1..16; exp_active high 8 cycles; back to IDLE 28 cycles after the edge.
- Bomb at col=2, row=2, RANGE=2, EXPLODE -> exp_on at tiles (0..4, 2) and (2, 0..4); low at (3,3) and (5,2).
- Bomb at col=2, row=1 -> horizontal arm suppressed: (3,1) low, (2,0) and (2,3) high. Bomb at col=0, row=0 -> no pixel with x<48 or y<32 is lit.
- Hold A high through the whole cycle, then pulse again in ARMED and in the last COOL cycle -> exactly one bomb; a new placement only on an edge in IDLE.
- gameover asserted mid-ARMED at timer=5 -> IDLE next cycle, bomb_on=exp_on=0, no explosion. Same result with reset asserted instead.
- In ARMED, fuse_frame steps 0,1,2,3,0,1,2,3, each frame lasting FUSE/8 = 2 cycles.
